// File: rtl/ul_read_fifo_pkg.sv
// ============================================================================
// Module      : ul_read_fifo_pkg
// Description : Shared constants and width helpers for the UL read FIFO port.
//               Pointer and level widths derive from DEPTH_BITS here so the
//               control block and the storage agree on them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ul_read_fifo_pkg;

   // Width of the saturating dropped-word counter.
   localparam int OVR_CNT_WIDTH = 16;

   // Read/write pointers address N = 2^depth_bits words and wrap modulo N.
   function automatic int ptr_width(input int depth_bits);
      return depth_bits;
   endfunction

   // The fill level must represent 0..N inclusive, so it needs one extra bit.
   function automatic int level_width(input int depth_bits);
      return depth_bits + 1;
   endfunction

endpackage : ul_read_fifo_pkg

`default_nettype wire

// File: rtl/ul_fifo_mem.sv
// ============================================================================
// Module      : ul_fifo_mem
// Description : 2^ADDR_BITS x DATA_WIDTH storage array. Synchronous write,
//               asynchronous read by address. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ul_fifo_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_BITS-1:0]  i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_BITS-1:0]  i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];

   // Write the incoming word at the write address; storage is never cleared.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Show-ahead read: the addressed word is presented without a clock delay.
   assign o_rd_data = r_mem[i_rd_addr];

endmodule : ul_fifo_mem

`default_nettype wire

// File: rtl/ul_read_fifo_port.sv
// ============================================================================
// Module      : ul_read_fifo_port
// Description : Show-ahead FIFO feeding the UL read engine. One clock,
//               synchronous active-high reset, synchronous flush.
//               Build option UL_READ_FIFO_DROP_EN: the producer is never
//               back-pressured; words arriving while full (and not
//               draining) are dropped and counted in overrun_count.
//               Without it, in_ready deasserts while full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ul_read_fifo_port
   import ul_read_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_BITS = 4
) (
   input  logic                     s_ul_clk,
   input  logic                     s_ul_rst,
   input  logic                     flush,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     axis_port_valid,
   output logic [DATA_WIDTH-1:0]    axis_port_data,
   input  logic                     axis_port_ready,
   output logic [DEPTH_BITS:0]      fill_level
`ifdef UL_READ_FIFO_DROP_EN
   ,
   output logic [OVR_CNT_WIDTH-1:0] overrun_count
`endif
);

   localparam int PTR_W = ptr_width(DEPTH_BITS);
   localparam int LVL_W = level_width(DEPTH_BITS);

   localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
   localparam logic [LVL_W-1:0] c_lvl_one  = LVL_W'(1);
   localparam logic [LVL_W-1:0] c_lvl_full = LVL_W'(1) << DEPTH_BITS;

   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [LVL_W-1:0]      r_level;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic [DATA_WIDTH-1:0] w_rd_data;

   // Valid comes only from the registered level, never from axis_port_ready.
   assign w_full          = (r_level == c_lvl_full);
   assign axis_port_valid = (r_level != '0);
   assign w_pop           = axis_port_valid && axis_port_ready;
   assign axis_port_data  = w_rd_data;
   assign fill_level      = r_level;

`ifdef UL_READ_FIFO_DROP_EN
   logic                     w_drop;
   logic [OVR_CNT_WIDTH-1:0] r_ovr_cnt;

   // Producer is always accepted; a full FIFO only takes the word if a pop
   // frees a slot in the same cycle, otherwise the word is dropped.
   assign in_ready = !s_ul_rst && !flush;
   assign w_push   = in_valid && in_ready && (!w_full || w_pop);
   assign w_drop   = in_valid && in_ready && w_full && !w_pop;
   assign overrun_count = r_ovr_cnt;

   // Saturating count of dropped words; reset and flush clear it.
   always_ff @(posedge s_ul_clk) begin
      if (s_ul_rst || flush) begin
         r_ovr_cnt <= '0;
      end else if (w_drop && (r_ovr_cnt != '1)) begin
         r_ovr_cnt <= r_ovr_cnt + OVR_CNT_WIDTH'(1);
      end
   end
`else
   // Backpressure: refuse while full even if a pop happens this cycle.
   assign in_ready = !s_ul_rst && !w_full;
   assign w_push   = in_valid && in_ready && !flush;
`endif

   // Pointer and level bookkeeping; flush outranks any concurrent push/pop.
   always_ff @(posedge s_ul_clk) begin
      if (s_ul_rst || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_lvl_one;
            2'b01:   r_level <= r_level - c_lvl_one;
            default: r_level <= r_level;
         endcase
      end
   end

   ul_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (PTR_W)
   ) u_mem (
      .clk       (s_ul_clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wptr),
      .i_wr_data (in_data),
      .i_rd_addr (r_rptr),
      .o_rd_data (w_rd_data)
   );

endmodule : ul_read_fifo_port

`default_nettype wire

// File: tb/tb_ul_read_fifo_port.sv
// ============================================================================
// Module      : tb_ul_read_fifo_port
// Description : Directed scoreboard bench for ul_read_fifo_port (default
//               depth 16, width 32). Honours UL_READ_FIFO_DROP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ul_read_fifo_port;

   logic        s_ul_clk = 1'b0;
   logic        s_ul_rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        axis_port_valid;
   logic [31:0] axis_port_data;
   logic        axis_port_ready = 1'b0;
   logic [4:0]  fill_level;
`ifdef UL_READ_FIFO_DROP_EN
   logic [15:0] overrun_count;
`endif

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   logic [31:0] q[$];
   int unsigned m_ovr = 0;

   always #5 s_ul_clk = ~s_ul_clk;

   ul_read_fifo_port #(.DATA_WIDTH(32), .DEPTH_BITS(4)) dut (
      .s_ul_clk        (s_ul_clk),
      .s_ul_rst        (s_ul_rst),
      .flush           (flush),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .axis_port_valid (axis_port_valid),
      .axis_port_data  (axis_port_data),
      .axis_port_ready (axis_port_ready),
      .fill_level      (fill_level)
`ifdef UL_READ_FIFO_DROP_EN
      ,
      .overrun_count   (overrun_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Inputs are applied 1 time unit after a rising edge; the model's view of
   // the current state is compared before the next edge, then updated.
   task automatic step(input logic fl, input logic v, input logic [31:0] d, input logic rdy);
      logic full, e_pop, e_push, e_rdy, e_drop;
      in_data = d; in_valid = v; axis_port_ready = rdy; flush = fl;
      #1;
      full   = (q.size() == 16);
      e_pop  = (q.size() != 0) && rdy;
`ifdef UL_READ_FIFO_DROP_EN
      e_rdy  = !fl;
      e_push = v && e_rdy && (!full || e_pop);
      e_drop = v && e_rdy && full && !e_pop;
      chk("overrun_count", 32'(overrun_count), m_ovr);
`else
      e_rdy  = !full;
      e_push = v && !full && !fl;
      e_drop = 1'b0;
`endif
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("valid", 32'(axis_port_valid), 32'(q.size() != 0));
      chk("fill_level", 32'(fill_level), q.size());
      if (q.size() != 0) chk("data", axis_port_data, q[0]);
      @(posedge s_ul_clk);
      if (fl) begin
         q.delete();
         m_ovr = 0;
      end else begin
         if (e_pop) void'(q.pop_front());
         if (e_push) q.push_back(d);
         if (e_drop && m_ovr != 32'hFFFF) m_ovr++;
      end
      #1;
   endtask

   task automatic do_reset();
      s_ul_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; axis_port_ready = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge s_ul_clk);
      #1;
      chk("rst_level", 32'(fill_level), 32'd0);
      chk("rst_valid", 32'(axis_port_valid), 32'd0);
`ifdef UL_READ_FIFO_DROP_EN
      chk("rst_ovr", 32'(overrun_count), 32'd0);
`endif
      s_ul_rst = 1'b0;
      q.delete();
      m_ovr = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      chk("drained", q.size(), 32'd0);
   endtask

   initial begin
      int mode;
      int pushed;
      @(posedge s_ul_clk);
      #1;
      do_reset();

      // First-word latency
      step(1'b0, 1'b1, 32'hA5A5_0001, 1'b0);
      chk("lat_valid", 32'(axis_port_valid), 32'd1);
      chk("lat_data", axis_port_data, 32'hA5A5_0001);
      chk("lat_level", 32'(fill_level), 32'd1);
      drain();

      // Fill to 16, check full behaviour, drain in order
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i), 1'b0);
      chk("full_level", 32'(fill_level), 32'd16);
      step(1'b0, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         chk("order", axis_port_data, 32'(i));
         step(1'b0, 1'b0, 32'd0, 1'b1);
      end
      chk("empty_valid", 32'(axis_port_valid), 32'd0);

      // Full + simultaneous push/pop
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
      step(1'b0, 1'b1, 32'h99, 1'b1);
`ifdef UL_READ_FIFO_DROP_EN
      chk("pp_level", 32'(fill_level), 32'd16);
`else
      chk("pp_level", 32'(fill_level), 32'd15);
`endif
      drain();

`ifdef UL_READ_FIFO_DROP_EN
      // Overrun counting and saturation
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hBAD0 + 32'(i), 1'b0);
      chk("ovr3", 32'(overrun_count), 32'd3);
      in_valid = 1'b1; in_data = 32'hDEAD; axis_port_ready = 1'b0;
      for (int i = 0; i < 70000; i++) @(posedge s_ul_clk);
      #1;
      m_ovr = 32'hFFFF;
      chk("ovr_sat", 32'(overrun_count), 32'hFFFF);
      drain();
`endif

      // Flush with concurrent push and pop
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h300 + 32'(i), 1'b0);
      step(1'b1, 1'b1, 32'hF00D, 1'b1);
      chk("flush_level", 32'(fill_level), 32'd0);
      chk("flush_valid", 32'(axis_port_valid), 32'd0);
`ifdef UL_READ_FIFO_DROP_EN
      chk("flush_ovr", 32'(overrun_count), 32'd0);
`endif
      step(1'b0, 1'b0, 32'd0, 1'b0);

      // Pointer wrap: level oscillates 0..3 over 40 words
      mode = 0; pushed = 0;
      for (int i = 0; i < 200 && (pushed < 40 || q.size() != 0); i++) begin
         if (mode == 0) begin
            step(1'b0, 1'b1, 32'h400 + 32'(pushed), 1'b0);
            pushed++;
            if (q.size() == 3 || pushed == 40) mode = 1;
         end else begin
            step(1'b0, 1'b0, 32'd0, 1'b1);
            if (q.size() == 0) mode = 0;
         end
      end
      chk("wrap_pushed", 32'(pushed), 32'd40);
      chk("wrap_empty", 32'(axis_port_valid), 32'd0);

      // Reset in mid-operation
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'h500 + 32'(i), 1'b0);
      chk("pre_rst_level", 32'(fill_level), 32'd7);
      do_reset();
      step(1'b0, 1'b0, 32'd0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_ul_read_fifo_port

`default_nettype wire

// File: doc/ul_read_fifo_port.md
UL_READ_FIFO_PORT -- requirements
Module: ul_read_fifo_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the word width; it matches the UL read data width.
REQ-002 SHALL have parameter DEPTH_BITS, default 4, giving FIFO depth N = 2^DEPTH_BITS words.
REQ-003 SHALL have port s_ul_clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port s_ul_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous FIFO clear.
REQ-006 SHALL have port in_data, input, DATA_WIDTH: producer word.
REQ-007 SHALL have port in_valid, input, 1 bit: producer word present.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 SHALL have port axis_port_valid, output, 1 bit: FIFO head word available.
REQ-010 SHALL have port axis_port_data, output, DATA_WIDTH: FIFO head word.
REQ-011 SHALL have port axis_port_ready, input, 1 bit: the UL read engine requests a word.
REQ-012 SHALL have port fill_level, output, DEPTH_BITS+1: the current word count, 0..N.
REQ-013 SHALL have port overrun_count, output, 16 bits: dropped-word count; the port exists only with UL_READ_FIFO_DROP_EN.

Function
REQ-014 SHALL push when in_valid && in_ready, and pop when axis_port_valid && axis_port_ready.
REQ-015 SHALL use show-ahead output: axis_port_data equals the head word whenever axis_port_valid=1.
REQ-016 SHALL assert axis_port_valid iff fill_level != 0.
REQ-017 SHALL make a word pushed in cycle n visible on axis_port_valid/axis_port_data in cycle n+1 (latency 1).
REQ-018 SHALL hold axis_port_data stable while axis_port_valid=1 and no pop occurs.
REQ-019 SHALL, on simultaneous push and pop, leave fill_level unchanged and advance both pointers.
REQ-020 SHALL use DEPTH_BITS-bit read/write pointers that wrap modulo N without skipping or duplicating words.
REQ-021 SHALL, when empty, ignore axis_port_ready; no pop and no underflow.
REQ-022 SHALL give flush priority over push and pop in the same cycle: pointers=0, fill_level=0, axis_port_valid=0, and any concurrent input word is discarded.
REQ-023 SHALL not combinationally depend axis_port_valid on axis_port_ready; the downstream engine holds ready until valid.

Reset
REQ-024 SHALL, while s_ul_rst=1, force pointers=0, fill_level=0, axis_port_valid=0, and overrun_count=0 where present.
REQ-025 SHALL drive in_ready=0 during reset, and discard a mid-operation reset's stored words without emitting them.
REQ-026 SHALL leave FIFO storage contents unreset; axis_port_data is don't-care while valid=0.

Configuration
REQ-027 SHALL provide macro UL_READ_FIFO_DROP_EN.
REQ-028 SHALL, without UL_READ_FIFO_DROP_EN, use backpressure: in_ready = (fill_level != N); no push while full, even with a same-cycle pop.
REQ-029 SHALL, with UL_READ_FIFO_DROP_EN, hold in_ready=1 outside reset/flush and accept a word when not full or when a pop occurs that cycle.
REQ-030 SHALL, with UL_READ_FIFO_DROP_EN, drop the word when in_valid && full && no pop, and increment overrun_count, saturating at 0xFFFF.
REQ-031 SHALL, with UL_READ_FIFO_DROP_EN, have flush clear overrun_count.

Structure
REQ-032 SHALL place OVR_CNT_WIDTH=16 and the pointer/level width derivation in shared package ul_read_fifo_pkg.
REQ-033 SHALL put storage in sub-module ul_fifo_mem: N x DATA_WIDTH, synchronous write, asynchronous read by address; the control logic lives in ul_read_fifo_port.

Verification
REQ-034 SHALL cover: reset, then push 0xA5A5_0001 at cycle 0 -> axis_port_valid=1 with data 0xA5A5_0001 at cycle 1, fill_level=1.
REQ-035 SHALL cover: push 16 words 0..15 with ready=0 -> fill_level=16; without the macro in_ready=0; with ready=1, 16 pops return 0..15 in order, then valid=0.
REQ-036 SHALL cover: at fill_level=16, same-cycle push 0x99 and pop -> without the macro push refused, level 15; with the macro push accepted, level 16, 0x99 last out.
REQ-037 SHALL cover, with the macro: full FIFO, 3 pushes without pops -> overrun_count=3, contents unchanged; 70000 drops -> overrun_count=0xFFFF.
REQ-038 SHALL cover: level 5, flush with concurrent push and pop -> next cycle fill_level=0, valid=0, overrun_count=0.
REQ-039 SHALL cover: pointer wrap -> 40 interleaved push/pop words with level oscillating 0..3 are read back in order with no loss; s_ul_rst at level 7 -> level 0 next cycle.
